// File: rtl/counter_table_drain.sv
// rtl/counter_table_drain.sv - eight-entry counter table with an in-order valid/ready drain engine
// Optional feature macro: COUNTER_TABLE_DRAIN_CLEAR_ON_READ_EN (each fetched entry is cleared as it is read)
module counter_table_drain #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_inc_valid,
    input  logic [AW-1:0]    io_inc_addr,
    input  logic             io_drain_start,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [AW-1:0]    io_out_addr,
    output logic [WIDTH-1:0] io_out_data,
    output logic             io_out_last,
    output logic             io_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             last_q, last_d;

    // Next table contents: optional clear of the entry being fetched, then the increment on top
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
`ifdef COUNTER_TABLE_DRAIN_CLEAR_ON_READ_EN
            if (state_q == FETCH && ptr_q == AW'(i)) begin
                mem_d[i] = '0;
            end
`endif
            // Addresses beyond DEPTH never match any entry, so they fall through as no-ops
            if (io_inc_valid && io_inc_addr == AW'(i)) begin
                mem_d[i] = mem_d[i] + WIDTH'(1);
            end
        end
    end

    // Counter storage; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Drain FSM: IDLE waits for start, FETCH snapshots one entry, SEND holds it until accepted
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (io_drain_start) begin
                    state_d = FETCH;
                    ptr_d   = '0;
                end
            end
            FETCH: begin
                // mem_q is the pre-increment value, so a same-cycle increment is not seen here
                data_d  = mem_q[ptr_q];
                addr_d  = ptr_q;
                last_d  = (ptr_q == AW'(DEPTH - 1));
                state_d = SEND;
            end
            SEND: begin
                if (io_out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output word registers; the word only changes in FETCH, so it is stable while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    // Outputs are decoded only from registers; io_out_ready never reaches an output combinationally
    assign io_out_valid = (state_q == SEND);
    assign io_busy      = (state_q != IDLE);
    assign io_out_addr  = addr_q;
    assign io_out_data  = data_q;
    assign io_out_last  = last_q;

endmodule

// File: tb/tb_counter_table_drain.sv
// tb/tb_counter_table_drain.sv - directed self-checking bench for counter_table_drain
module tb_counter_table_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_inc_valid;
    logic [2:0]  io_inc_addr;
    logic        io_drain_start;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [2:0]  io_out_addr;
    logic [31:0] io_out_data;
    logic        io_out_last;
    logic        io_busy;

    logic        s_inc_valid;
    logic [2:0]  s_inc_addr;
    logic        s_drain_start;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [2:0]  s_out_addr;
    logic [3:0]  s_out_data;
    logic        s_out_last;
    logic        s_busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model [8];
    logic [31:0] got_data [8];
    logic [2:0]  got_addr [8];
    logic        got_last [8];
    int          nwords;
    int          busy_cycles;
    int          first_valid;

    always #5 clk = ~clk;

    counter_table_drain #(.DEPTH(8), .WIDTH(32), .AW(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_inc_valid   (io_inc_valid),
        .io_inc_addr    (io_inc_addr),
        .io_drain_start (io_drain_start),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_addr    (io_out_addr),
        .io_out_data    (io_out_data),
        .io_out_last    (io_out_last),
        .io_busy        (io_busy)
    );

    // Narrow instance so counter wrap-around can be reached in a few increments
    counter_table_drain #(.DEPTH(8), .WIDTH(4), .AW(3)) dut_small (
        .clk            (clk),
        .reset          (reset),
        .io_inc_valid   (s_inc_valid),
        .io_inc_addr    (s_inc_addr),
        .io_drain_start (s_drain_start),
        .io_out_valid   (s_out_valid),
        .io_out_ready   (s_out_ready),
        .io_out_addr    (s_out_addr),
        .io_out_data    (s_out_data),
        .io_out_last    (s_out_last),
        .io_busy        (s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic inc(input logic [2:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            io_inc_valid = 1'b1;
            io_inc_addr  = a;
            model[a]     = model[a] + 32'd1;
            tick();
        end
        io_inc_valid = 1'b0;
    endtask

    // Start a drain and follow it cycle by cycle; cyc=1 is the first FETCH cycle
    task automatic run_drain(input int inc_cyc, input logic [2:0] inc_a, input int stall_addr,
                             input int restart_cyc, input int abort_addr);
        int stall_cnt;
        stall_cnt    = 0;
        nwords       = 0;
        busy_cycles  = 0;
        first_valid  = -1;
        io_out_ready = 1'b1;
        io_drain_start = 1'b1;
        tick();
        io_drain_start = 1'b0;
        for (int cyc = 1; cyc < 64; cyc++) begin
            if (!io_busy) break;
            busy_cycles++;
            if (io_out_valid && first_valid < 0) first_valid = cyc;
            if (abort_addr >= 0 && io_out_valid && int'(io_out_addr) == abort_addr) begin
                reset = 1'b1;
                io_out_ready = 1'b0;
                tick();
                reset = 1'b0;
                io_out_ready = 1'b1;
                check("abort_valid", io_out_valid, 0);
                check("abort_busy", io_busy, 0);
                check("abort_data", io_out_data, 0);
                return;
            end
            io_out_ready = 1'b1;
            if (stall_addr >= 0 && io_out_valid && int'(io_out_addr) == stall_addr && stall_cnt < 5) begin
                check("stall_valid", io_out_valid, 1);
                check("stall_addr", io_out_addr, stall_addr);
                check("stall_data", io_out_data, model[stall_addr]);
                io_out_ready = 1'b0;
                stall_cnt++;
            end
            if (io_out_valid && io_out_ready && nwords < 8) begin
                got_data[nwords] = io_out_data;
                got_addr[nwords] = io_out_addr;
                got_last[nwords] = io_out_last;
                nwords++;
            end
            io_inc_valid   = (cyc == inc_cyc);
            io_inc_addr    = inc_a;
            io_drain_start = (cyc == restart_cyc);
            tick();
        end
        io_inc_valid   = 1'b0;
        io_drain_start = 1'b0;
        check("drain_done", io_busy, 0);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, nwords, 8);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_addr"}, got_addr[i], i);
            check({tag, "_data"}, got_data[i], model[i]);
            check({tag, "_last"}, got_last[i], (i == 7) ? 1 : 0);
        end
    endtask

    // A clear-on-read drain empties the table
    task automatic after_drain();
`ifdef COUNTER_TABLE_DRAIN_CLEAR_ON_READ_EN
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
`endif
    endtask

    task automatic small_read2(output logic [3:0] d, output logic found);
        found = 1'b0;
        d = '0;
        s_drain_start = 1'b1;
        tick();
        s_drain_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (s_out_valid && s_out_addr == 3'd2) begin
                d = s_out_data;
                found = 1'b1;
            end
            if (!s_busy) break;
            tick();
        end
    endtask

    initial begin
        logic [3:0] sd;
        logic       sf;
        reset = 1'b1;
        io_inc_valid = 1'b0;
        io_inc_addr = '0;
        io_drain_start = 1'b0;
        io_out_ready = 1'b1;
        s_inc_valid = 1'b0;
        s_inc_addr = 3'd2;
        s_drain_start = 1'b0;
        s_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_valid", io_out_valid, 0);
        check("rst_data", io_out_data, 0);
        check("rst_addr", io_out_addr, 0);
        check("rst_last", io_out_last, 0);
        check("rst_busy", io_busy, 0);

        run_drain(-1, 3'd0, -1, -1, -1);
        check_words("zero");
        check("zero_busy_cycles", busy_cycles, 16);
        after_drain();

        inc(3'd3, 5);
        inc(3'd7, 1);
        run_drain(-1, 3'd0, -1, -1, -1);
        check_words("inc");
        check("inc_first_valid", first_valid, 2);
        check("inc_busy_cycles", busy_cycles, 16);
        after_drain();

        inc(3'd4, 2);
        run_drain(-1, 3'd0, 4, 6, -1);
        check_words("stall");
        check("stall_busy_cycles", busy_cycles, 21);
        after_drain();
        tick();
        check("restart_ignored_busy", io_busy, 0);
        check("restart_ignored_valid", io_out_valid, 0);

        inc(3'd1, 3);
        run_drain(3, 3'd1, -1, -1, -1);
        check_words("samecyc");
        after_drain();
        model[1] = model[1] + 32'd1;
        run_drain(-1, 3'd0, -1, -1, -1);
        check_words("samecyc2");
        after_drain();

        inc(3'd6, 2);
        inc(3'd5, 1);
        run_drain(-1, 3'd0, -1, -1, 5);
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
        run_drain(-1, 3'd0, -1, -1, -1);
        check_words("post_reset");

        for (int k = 0; k < 15; k++) begin
            s_inc_valid = 1'b1;
            tick();
        end
        s_inc_valid = 1'b0;
        small_read2(sd, sf);
        check("wrap_found_max", sf, 1);
`ifdef COUNTER_TABLE_DRAIN_CLEAR_ON_READ_EN
        check("wrap_max", sd, 4'hF);
        for (int k = 0; k < 15; k++) begin
            s_inc_valid = 1'b1;
            tick();
        end
        s_inc_valid = 1'b0;
`else
        check("wrap_max", sd, 4'hF);
`endif
        s_inc_valid = 1'b1;
        tick();
        s_inc_valid = 1'b0;
        small_read2(sd, sf);
        check("wrap_found_zero", sf, 1);
        check("wrap_zero", sd, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
